// File: rtl/sar_logic_param_if.sv
// Handshake and CDAC/comparator signal bundle for the SAR control logic.
// The slave side is the converter controller; the master side drives requests and the comparator.
interface sar_logic_param_if #(
   parameter int unsigned N_BIT = 6
);
   logic             START;
   logic             CONT;
   logic             COMP_OUT;
   logic [N_BIT-1:0] DIGITAL_OUT;
   logic             COMP_CLK;
   logic             SC;
   logic [N_BIT:0]   SDAC;
   logic             EOC;
   logic             BUSY;

   modport master (
      output START, CONT, COMP_OUT,
      input  DIGITAL_OUT, COMP_CLK, SC, SDAC, EOC, BUSY
   );

   modport slave (
      input  START, CONT, COMP_OUT,
      output DIGITAL_OUT, COMP_CLK, SC, SDAC, EOC, BUSY
   );
endinterface

// File: rtl/sar_logic_param.sv
// SAR ADC sequencer: sampling, comparator strobes and binary-search trial register,
// with single-shot or continuous conversion and a registered result plus one-cycle EOC.
module sar_logic_param #(
   parameter int unsigned N_BIT         = 6,
   parameter int unsigned SAMPLE_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   sar_logic_param_if.slave sar
);
   localparam int unsigned      IdxW       = (N_BIT > 1) ? $clog2(N_BIT) : 1;
   localparam logic [IdxW-1:0]  IdxTop     = IdxW'(N_BIT - 1);
   localparam logic [7:0]       SampleLast = 8'(SAMPLE_CYCLES - 1);
   localparam logic [N_BIT-1:0] MsbTrial   = {1'b1, {(N_BIT-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [IdxW-1:0]  idx_dec;
   logic             phase_q, phase_d;
   logic [N_BIT-1:0] r_q, r_d;
   logic [N_BIT-1:0] dout_q, dout_d;
   logic             sc_q, sc_d;
   logic             comp_clk_q, comp_clk_d;
   logic             eoc_q, eoc_d;

   assign idx_dec = idx_q - IdxW'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         phase_q    <= 1'b0;
         r_q        <= '0;
         dout_q     <= '0;
         sc_q       <= 1'b0;
         comp_clk_q <= 1'b0;
         eoc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         r_q        <= r_d;
         dout_q     <= dout_d;
         sc_q       <= sc_d;
         comp_clk_q <= comp_clk_d;
         eoc_q      <= eoc_d;
      end
   end

   // Next-state values double as next output values, so every output is a flop.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      phase_d    = phase_q;
      r_d        = r_q;
      dout_d     = dout_q;
      sc_d       = sc_q;
      comp_clk_d = comp_clk_q;
      eoc_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sar.START) begin
               state_d    = StSample;
               cnt_d      = '0;
               sc_d       = 1'b1;
               r_d        = '0;
               comp_clk_d = 1'b0;
            end
         end
         StSample: begin
            if (cnt_q == SampleLast) begin
               state_d    = StConv;
               cnt_d      = '0;
               sc_d       = 1'b0;
               r_d        = MsbTrial;
               idx_d      = IdxTop;
               phase_d    = 1'b0;
               comp_clk_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StConv: begin
            if (!phase_q) begin
               // Resolve the current bit and raise the next trial bit on the same edge.
               r_d[idx_q] = sar.COMP_OUT;
               if (idx_q != '0) begin
                  r_d[idx_dec] = 1'b1;
               end
               comp_clk_d = 1'b0;
               phase_d    = 1'b1;
            end else if (idx_q == '0) begin
               state_d = StDone;
               dout_d  = r_q;
               eoc_d   = 1'b1;
               phase_d = 1'b0;
            end else begin
               idx_d      = idx_dec;
               phase_d    = 1'b0;
               comp_clk_d = 1'b1;
            end
         end
         StDone: begin
            r_d = '0;
            if (sar.CONT) begin
               state_d = StSample;
               cnt_d   = '0;
               sc_d    = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign sar.DIGITAL_OUT = dout_q;
   assign sar.COMP_CLK    = comp_clk_q;
   assign sar.SC          = sc_q;
   assign sar.SDAC        = {r_q, sc_q};
   assign sar.EOC         = eoc_q;
   assign sar.BUSY        = (state_q != StIdle);
endmodule

// File: tb/tb_sar_logic_param.sv
// Bench for sar_logic_param: 6-bit and 10-bit instances, behavioural comparators,
// a scoreboard of expected results and EOC cycles, and per-cycle output invariants.
module tb_sar_logic_param;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sar_logic_param_if #(.N_BIT(6))  if6 ();
   sar_logic_param_if #(.N_BIT(10)) if10 ();

   sar_logic_param #(.N_BIT(6), .SAMPLE_CYCLES(2)) u_dut6 (
      .CLK (clk),
      .RST (rst),
      .sar (if6)
   );

   sar_logic_param #(.N_BIT(10), .SAMPLE_CYCLES(4)) u_dut10 (
      .CLK (clk),
      .RST (rst),
      .sar (if10)
   );

   // mode 0: behavioural comparator, 1: tied high, 2: tied low
   logic [1:0] mode6 = 2'd0;
   logic [5:0] code6 = '0;
   logic [9:0] code10 = '0;
   assign if6.COMP_OUT  = (mode6 == 2'd1) ? 1'b1 :
                          (mode6 == 2'd2) ? 1'b0 : (code6 >= if6.SDAC[6:1]);
   assign if10.COMP_OUT = (code10 >= if10.SDAC[10:1]);

   typedef struct {
      logic [15:0] code;
      int unsigned cyc;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [5:0] code;
      logic [5:0] dout;
   } vec_t;

   exp_t        sb6[$];
   exp_t        sb10[$];
   exp_t        e6, e10;
   logic [15:0] trial6[$];
   logic [15:0] last6 = '0;
   logic [15:0] last10 = '0;
   int          sc10_cnt = 0;
   vec_t        vecs[6];
   logic [5:0]  cont_codes[4];
   int unsigned next_eoc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
   endtask

   // Trial word at bit k of a successful search for 'code': bits above k resolved, bit k set.
   function automatic logic [15:0] trial_of(input logic [15:0] code, input int k);
      return ((code >> (k + 1)) << (k + 1)) | (16'd1 << k);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last6 = '0;
      end else begin
         check("sc_and_compclk6", 32'(if6.SC & if6.COMP_CLK), 32'd0);
         check("sdac0_eq_sc6", 32'(if6.SDAC[0]), 32'(if6.SC));
         if (if6.COMP_CLK) begin
            check("compclk_busy6", 32'(if6.BUSY), 32'd1);
            trial6.push_back(16'(if6.SDAC[6:1]));
         end
         if (if6.EOC) begin
            if (sb6.size() == 0) begin
               check("unexpected_eoc6", 32'd1, 32'd0);
            end else begin
               e6 = sb6.pop_front();
               check("dout6", 32'(if6.DIGITAL_OUT), 32'(e6.code));
               check("eoc_cycle6", cyc, e6.cyc);
               last6 = e6.code;
            end
         end else begin
            check("dout6_hold", 32'(if6.DIGITAL_OUT), 32'(last6));
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         last10 = '0;
      end else begin
         check("sc_and_compclk10", 32'(if10.SC & if10.COMP_CLK), 32'd0);
         if (if10.SC) sc10_cnt++;
         if (if10.EOC) begin
            if (sb10.size() == 0) begin
               check("unexpected_eoc10", 32'd1, 32'd0);
            end else begin
               e10 = sb10.pop_front();
               check("dout10", 32'(if10.DIGITAL_OUT), 32'(e10.code));
               check("eoc_cycle10", cyc, e10.cyc);
               last10 = e10.code;
            end
         end else begin
            check("dout10_hold", 32'(if10.DIGITAL_OUT), 32'(last10));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sb6(input int budget);
      for (int k = 0; k < budget && sb6.size() != 0; k++) @(negedge clk);
      check("eoc6_timeout", 32'(sb6.size()), 32'd0);
   endtask

   task automatic run6(input logic [1:0] md, input logic [5:0] cd, input logic [5:0] exp_d);
      mode6 = md;
      code6 = cd;
      trial6.delete();
      if6.START = 1'b1;
      sb6.push_back('{16'(exp_d), cyc + 1 + 2 + 12});
      @(negedge clk);
      if6.START = 1'b0;
      wait_sb6(40);
      tick(2);
      check("busy6_after", 32'(if6.BUSY), 32'd0);
      check("compclk_pulses6", 32'(trial6.size()), 32'd6);
      for (int k = 0; k < 6 && k < trial6.size(); k++)
         check("trial6", 32'(trial6[k]), 32'(trial_of(16'(exp_d), 5 - k)));
   endtask

   initial begin
      vecs[0] = '{2'd0, 6'h2B, 6'h2B};
      vecs[1] = '{2'd1, 6'h00, 6'h3F};
      vecs[2] = '{2'd2, 6'h3F, 6'h00};
      vecs[3] = '{2'd0, 6'h00, 6'h00};
      vecs[4] = '{2'd0, 6'h3F, 6'h3F};
      vecs[5] = '{2'd0, 6'h15, 6'h15};
      cont_codes[0] = 6'h11;
      cont_codes[1] = 6'h2E;
      cont_codes[2] = 6'h07;
      cont_codes[3] = 6'h38;

      if6.START  = 1'b0;
      if6.CONT   = 1'b0;
      if10.START = 1'b0;
      if10.CONT  = 1'b0;

      tick(2);
      check("reset_outs6", 32'({if6.DIGITAL_OUT, if6.COMP_CLK, if6.SC, if6.SDAC, if6.EOC}), 32'd0);
      check("reset_busy6", 32'(if6.BUSY), 32'd0);
      check("reset_outs10", 32'({if10.DIGITAL_OUT, if10.SC, if10.SDAC, if10.EOC, if10.BUSY}),
            32'd0);
      #2 rst = 1'b0;
      tick(1);

      for (int v = 0; v < 6; v++) run6(vecs[v].mode, vecs[v].code, vecs[v].dout);

      // Continuous mode: one START, new comparator input per conversion, CONT dropped late.
      mode6 = 2'd0;
      code6 = cont_codes[0];
      if6.CONT  = 1'b1;
      if6.START = 1'b1;
      next_eoc  = cyc + 15;
      sb6.push_back('{16'(cont_codes[0]), next_eoc});
      @(negedge clk);
      if6.START = 1'b0;
      for (int i = 1; i < 4; i++) begin
         wait_sb6(40);
         code6 = cont_codes[i];
         next_eoc += 15;
         sb6.push_back('{16'(cont_codes[i]), next_eoc});
      end
      tick(5);
      if6.CONT = 1'b0;
      wait_sb6(40);
      tick(2);
      check("busy6_cont_off", 32'(if6.BUSY), 32'd0);
      tick(20);
      check("busy6_stays_idle", 32'(if6.BUSY), 32'd0);

      // START during SAMPLE and CONV must be ignored.
      code6 = 6'h26;
      if6.START = 1'b1;
      sb6.push_back('{16'h26, cyc + 15});
      @(negedge clk);
      if6.START = 1'b1;
      @(negedge clk);
      if6.START = 1'b0;
      tick(3);
      if6.START = 1'b1;
      tick(3);
      if6.START = 1'b0;
      wait_sb6(40);
      tick(20);
      check("busy6_after_ignore", 32'(if6.BUSY), 32'd0);

      // Asynchronous reset in the middle of CONV.
      code6 = 6'h19;
      if6.START = 1'b1;
      @(negedge clk);
      if6.START = 1'b0;
      tick(7);
      check("busy6_before_abort", 32'(if6.BUSY), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_outs6", 32'({if6.DIGITAL_OUT, if6.COMP_CLK, if6.SC, if6.SDAC, if6.EOC}),
            32'd0);
      check("abort_busy6", 32'(if6.BUSY), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      tick(20);
      run6(2'd0, 6'h19, 6'h19);

      // 10-bit instance, 4 sample cycles.
      code10   = 10'h2AA;
      sc10_cnt = 0;
      if10.START = 1'b1;
      sb10.push_back('{16'h2AA, cyc + 1 + 24});
      @(negedge clk);
      if10.START = 1'b0;
      for (int k = 0; k < 60 && sb10.size() != 0; k++) @(negedge clk);
      check("eoc10_timeout", 32'(sb10.size()), 32'd0);
      tick(2);
      check("sc10_high_cycles", 32'(sc10_cnt), 32'd4);
      check("busy10_after", 32'(if10.BUSY), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sar_logic_param.md
Name: sar_logic_param

Overview:
- Parametrised successor-generation SAR ADC control logic. It sequences sampling, comparator strobes and binary-search DAC switching for an N_BIT capacitive SAR ADC.
- Adds single-shot and continuous conversion modes, a START handshake and a BUSY flag.
- Sits between the comparator and the CDAC switch drivers, and delivers a registered result with a one-cycle EOC strobe.

Parameters:
- N_BIT, 6, resolution in bits; legal range 2..16.
- SAMPLE_CYCLES, 2, number of CLK cycles SC is held high per conversion; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  conversion request; sampled only in IDLE.
- CONT  input  1  1 = continuous mode, 0 = single-shot; sampled in DONE.
- COMP_OUT  input  1  comparator decision; 1 = Vin above DAC level.
- DIGITAL_OUT  output  N_BIT  last completed conversion result; registered.
- COMP_CLK  output  1  comparator strobe.
- SC  output  1  sample switch control; 1 = track input.
- SDAC  output  N_BIT+1  CDAC switch controls. SDAC[N_BIT:1] = trial register R. SDAC[0] = dummy-cap switch, equal to SC.
- EOC  output  1  end-of-conversion strobe, one cycle.
- BUSY  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (RST=1, asynchronous):
  - state = IDLE; all counters = 0; R = 0.
  - DIGITAL_OUT=0, COMP_CLK=0, SC=0, SDAC=0, EOC=0, BUSY=0.
  - Reset mid-conversion aborts immediately. No EOC is produced and DIGITAL_OUT is cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - SC=0, COMP_CLK=0, R=0.
  - START=1 at an edge → SAMPLE at that edge.
- SAMPLE:
  - SC=1, SDAC[0]=1, R=0, COMP_CLK=0.
  - Lasts exactly SAMPLE_CYCLES cycles.
  - At the last edge: SC→0, R→1000…0 (MSB trial set), bit index i→N_BIT-1, phase→0. Enter CONV.
- CONV, two cycles per bit:
  - Phase 0: COMP_CLK=1. The edge ending phase 0 captures COMP_OUT:
    - COMP_OUT=0 → R[i] cleared; COMP_OUT=1 → R[i] kept.
    - If i>0, R[i-1] is set at the same edge.
    - COMP_CLK→0 at the same edge.
  - Phase 1: COMP_CLK=0 (DAC settling). The edge ending phase 1 decrements i, or enters DONE if i=0.
  - Total CONV duration: 2·N_BIT cycles.
- DONE (1 cycle):
  - Entry edge loads DIGITAL_OUT←R and sets EOC=1; BUSY stays 1.
  - Exit edge: CONT=1 → SAMPLE (continuous mode); CONT=0 → IDLE.
- Latency (START seen at edge e0):
  - EOC=1 in the cycle starting at edge e0+SAMPLE_CYCLES+2·N_BIT.
  - Continuous mode: EOC period = SAMPLE_CYCLES+2·N_BIT+1.
  - Single-shot with START held high: period is one cycle longer, because IDLE is re-entered.
- START outside IDLE is ignored; it is neither queued nor able to restart a conversion.
- CONT changes mid-conversion take effect only at DONE.
- DIGITAL_OUT holds its value between EOCs and changes only on the DONE entry edge.
- COMP_CLK is never high outside CONV phase 0. SC and COMP_CLK are never high simultaneously.

Test Plan:
- N_BIT=6, SAMPLE_CYCLES=2; single START pulse; behavioural comparator at code 0x2B → DIGITAL_OUT=0x2B. EOC high exactly once, 14 cycles after the START edge. SDAC[6:1] trial sequence 0x20,0x30,0x28,0x2C,0x2A,0x2B; COMP_CLK pulses 6 times.
- COMP_OUT tied 1 → DIGITAL_OUT=0x3F. COMP_OUT tied 0 → DIGITAL_OUT=0x00, with R sequence 0x20,0x10,0x08,0x04,0x02,0x01.
- CONT=1 with START pulsed once → EOC every 15 cycles. Comparator input changed between conversions → each DIGITAL_OUT matches its own input. Drop CONT mid-conversion → that conversion completes, then IDLE and BUSY=0.
- START pulsed during SAMPLE and CONV → no extra EOC and timing unchanged.
- RST asserted mid-CONV → all outputs 0 immediately, no EOC. After release, a new START gives a correct result.
- N_BIT=10, SAMPLE_CYCLES=4, code 0x2AA → DIGITAL_OUT=0x2AA, EOC 24 cycles after START, SC high exactly 4 cycles.
